// File: rtl/max_pool_stage.sv
// rtl/max_pool_stage.sv - 2x2 stride-2 streaming max-pool with optional ReLU
module max_pool_stage #(
  parameter int OUT  = 14,
  parameter int RELU = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        srt_pool,
  input  logic        in_valid,
  input  logic [15:0] result,
  input  logic        end_sig,
  output logic [15:0] pool_out,
  output logic        pool_valid,
  output logic        pool_done,
  output logic        busy
);
  localparam int PW = OUT / 2;
  localparam int CW = $clog2(OUT + 1);
  localparam int BD = 2 ** (CW - 1);
  localparam logic [CW-1:0] LAST     = CW'(OUT - 1);
  localparam logic [CW-1:0] PAIR_END = CW'(2 * PW - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]      row, col, cur_row, cur_col;
  logic signed [15:0] x, h, h_reg, above, win_max;
  logic signed [15:0] line_buf [BD];
  logic               accept, in_win, last_pix;

  // srt_pool forces the coincident pixel to be treated as (0,0) of a fresh frame
  assign accept   = in_valid && (state == ACTIVE || srt_pool);
  assign cur_row  = srt_pool ? '0 : row;
  assign cur_col  = srt_pool ? '0 : col;
  assign in_win   = (cur_row <= PAIR_END) && (cur_col <= PAIR_END);
  assign last_pix = (cur_row == LAST) && (cur_col == LAST);

  assign x       = (RELU != 0 && $signed(result) < 0) ? 16'sd0 : $signed(result);
  assign h       = (h_reg > x) ? h_reg : x;
  assign above   = line_buf[cur_col[CW-1:1]];
  assign win_max = (above > h) ? above : h;
  assign busy    = (state == ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (srt_pool)
      state_nx = ACTIVE;
    else if (state == ACTIVE && (end_sig || (accept && last_pix)))
      state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      h_reg      <= '0;
      pool_out   <= '0;
      pool_valid <= 1'b0;
      pool_done  <= 1'b0;
      for (int i = 0; i < BD; i++) line_buf[i] <= '0;
    end else begin
      pool_valid <= 1'b0;
      pool_done  <= 1'b0;
      if (accept && in_win) begin
        if (!cur_col[0]) begin
          h_reg <= x;
        end else if (!cur_row[0]) begin
          line_buf[cur_col[CW-1:1]] <= h;
        end else begin
          pool_out   <= win_max;
          pool_valid <= 1'b1;
          pool_done  <= (cur_row == PAIR_END) && (cur_col == PAIR_END);
        end
      end
      if (state_nx == IDLE) begin
        row <= '0;
        col <= '0;
      end else if (accept) begin
        if (cur_col == LAST) begin
          col <= '0;
          row <= (cur_row == LAST) ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end else if (srt_pool) begin
        row <= '0;
        col <= '0;
      end
    end
  end
endmodule

// File: tb/tb_max_pool_stage.sv
// tb/tb_max_pool_stage.sv - self-checking bench for max_pool_stage, three configurations in parallel
module tb_max_pool_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        srt_pool = 1'b0, in_valid = 1'b0, end_sig = 1'b0;
  logic [15:0] result = '0;
  logic [15:0] po [3];
  logic        pv [3], pd [3], bz [3];

  max_pool_stage #(.OUT(4), .RELU(0)) u0 (
    .clk(clk), .rst_n(rst_n), .srt_pool(srt_pool), .in_valid(in_valid), .result(result),
    .end_sig(end_sig), .pool_out(po[0]), .pool_valid(pv[0]), .pool_done(pd[0]), .busy(bz[0]));
  max_pool_stage #(.OUT(4), .RELU(1)) u1 (
    .clk(clk), .rst_n(rst_n), .srt_pool(srt_pool), .in_valid(in_valid), .result(result),
    .end_sig(end_sig), .pool_out(po[1]), .pool_valid(pv[1]), .pool_done(pd[1]), .busy(bz[1]));
  max_pool_stage #(.OUT(5), .RELU(0)) u2 (
    .clk(clk), .rst_n(rst_n), .srt_pool(srt_pool), .in_valid(in_valid), .result(result),
    .end_sig(end_sig), .pool_out(po[2]), .pool_valid(pv[2]), .pool_done(pd[2]), .busy(bz[2]));

  // Reference model: keeps the whole frame and pools each 2x2 window directly
  int          cfg_out  [3] = '{4, 4, 5};
  int          cfg_relu [3] = '{0, 1, 0};
  bit          m_act [3];
  int          m_idx [3];
  int          m_frame [3][25];
  logic [15:0] e_out [3];
  bit          e_val [3], e_done [3];

  int          n_cmp = 0, n_err = 0;
  int          dcnt0 = 0, dcnt2 = 0;
  logic [15:0] log0 [$];
  logic [15:0] log2 [$];

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_step();
    bit acc;
    int p, rr, cc, o, pw, v;
    for (int k = 0; k < 3; k++) begin
      e_val[k]  = 1'b0;
      e_done[k] = 1'b0;
      o  = cfg_out[k];
      pw = o / 2;
      acc = in_valid && (m_act[k] || srt_pool);
      if (srt_pool) m_idx[k] = 0;
      if (acc) begin
        p  = m_idx[k];
        rr = p / o;
        cc = p % o;
        v  = int'($signed(result));
        if (cfg_relu[k] != 0 && v < 0) v = 0;
        m_frame[k][p] = v;
        if (rr % 2 == 1 && cc % 2 == 1 && rr < 2 * pw && cc < 2 * pw) begin
          v = max2(max2(m_frame[k][p], m_frame[k][p-1]),
                   max2(m_frame[k][p-o], m_frame[k][p-o-1]));
          e_val[k]  = 1'b1;
          e_out[k]  = 16'(v);
          e_done[k] = (rr == 2 * pw - 1) && (cc == 2 * pw - 1);
        end
        m_idx[k] = p + 1;
      end
      if (srt_pool) begin
        m_act[k] = 1'b1;
      end else if (m_act[k] && (end_sig || (acc && m_idx[k] == o * o))) begin
        m_act[k] = 1'b0;
        m_idx[k] = 0;
      end
    end
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("pool_valid%0d", k), {15'b0, pv[k]}, {15'b0, e_val[k]});
      chk($sformatf("pool_done%0d", k),  {15'b0, pd[k]}, {15'b0, e_done[k]});
      chk($sformatf("busy%0d", k),       {15'b0, bz[k]}, {15'b0, m_act[k]});
      chk($sformatf("pool_out%0d", k),   po[k], e_out[k]);
    end
    if (pv[0] === 1'b1) log0.push_back(po[0]);
    if (pv[2] === 1'b1) log2.push_back(po[2]);
    if (pd[0] === 1'b1) dcnt0++;
    if (pd[2] === 1'b1) dcnt2++;
  endtask

  task automatic step(bit sp, bit iv, logic [15:0] r, bit es);
    srt_pool = sp;
    in_valid = iv;
    result   = r;
    end_sig  = es;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    srt_pool = 1'b0;
    in_valid = 1'b0;
    end_sig  = 1'b0;
    result   = '0;
    for (int k = 0; k < 3; k++) begin
      m_act[k]  = 1'b0;
      m_idx[k]  = 0;
      e_out[k]  = '0;
      e_val[k]  = 1'b0;
      e_done[k] = 1'b0;
    end
    #1;
    check_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    rst_n = 1'b1;
  endtask

  task automatic check_log0(string tag, int e0, int e1, int e2, int e3);
    int exp [4];
    exp = '{e0, e1, e2, e3};
    chk({tag, "_count"}, 16'(log0.size()), 16'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_val%0d", tag, i), (i < log0.size()) ? log0[i] : 16'hdead, 16'(exp[i]));
  endtask

  task automatic ramp_frame(int n, int base);
    for (int i = 1; i <= n; i++) step(i == 1, 1'b1, 16'(base + i), 1'b0);
  endtask

  logic [15:0] v;
  int          n;

  initial begin
    #2;
    do_reset();

    // 1..16 on a 4x4 frame
    log0.delete();
    dcnt0 = 0;
    ramp_frame(16, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_log0("t1", 6, 8, 14, 16);
    chk("t1_done_cnt", 16'(dcnt0), 16'd1);
    chk("t1_busy_after", {15'b0, bz[0]}, 16'd0);

    // negative stream, ReLU and pass-through configurations side by side
    for (int i = 1; i <= 16; i++) step(i == 1, 1'b1, (i == 11) ? 16'hffff : 16'hfffb, 1'b0);
    step(0, 0, 0, 0);

    // stalls after pixels 2 and 7
    log0.delete();
    for (int i = 1; i <= 16; i++) begin
      step(i == 1, 1'b1, 16'(i), 1'b0);
      if (i == 2 || i == 7) repeat (3) step(0, 0, 16'h1234, 0);
    end
    step(0, 0, 0, 0);
    check_log0("t3", 6, 8, 14, 16);

    // abort after 9 pixels, then a fresh frame ending with end_sig on its last pixel
    ramp_frame(9, 0);
    step(0, 0, 0, 1);
    step(0, 1, 16'h0777, 0);
    step(0, 0, 0, 0);
    log0.delete();
    dcnt0 = 0;
    for (int i = 1; i <= 16; i++) step(i == 1, 1'b1, 16'(i), i == 16);
    step(0, 0, 0, 0);
    check_log0("t4", 6, 8, 14, 16);
    chk("t4_done_cnt", 16'(dcnt0), 16'd1);

    // odd size: 5x5 frame, last row and column ignored
    log2.delete();
    dcnt2 = 0;
    ramp_frame(25, 0);
    step(0, 0, 0, 0);
    chk("t5_count", 16'(log2.size()), 16'd4);
    chk("t5_val0", (log2.size() > 0) ? log2[0] : 16'hdead, 16'd7);
    chk("t5_val1", (log2.size() > 1) ? log2[1] : 16'hdead, 16'd9);
    chk("t5_val2", (log2.size() > 2) ? log2[2] : 16'hdead, 16'd17);
    chk("t5_val3", (log2.size() > 3) ? log2[3] : 16'hdead, 16'd19);
    chk("t5_done_cnt", 16'(dcnt2), 16'd1);

    // reset mid-frame with large values, then a clean frame
    ramp_frame(10, 1000);
    do_reset();
    log0.delete();
    ramp_frame(16, 0);
    step(0, 0, 0, 0);
    check_log0("t6", 6, 8, 14, 16);

    // signed extremes
    log0.delete();
    for (int i = 1; i <= 16; i++) step(i == 1, 1'b1, (i % 2 == 1) ? 16'h8000 : 16'h7fff, 1'b0);
    step(0, 0, 0, 0);
    check_log0("t7", 32767, 32767, 32767, 32767);

    // back-to-back frames: new srt_pool in the pool_done cycle
    ramp_frame(16, 0);
    ramp_frame(16, 100);
    step(0, 0, 0, 0);

    // randomized frames with gaps, extremes, aborts and restarts
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(25, 8);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) step(0, 0, 16'($urandom), 0);
        case ($urandom_range(7, 0))
          0:       v = 16'h8000;
          1:       v = 16'h7fff;
          default: v = 16'($urandom);
        endcase
        step(i == 0, 1'b1, v, 1'b0);
      end
      if ($urandom_range(4, 0) == 0) step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
